// File: rtl/round_key_adder_if.sv
// round_key_adder_if: key-load, request and result signals between the S-AES round-key adder and its neighbours
interface round_key_adder_if;
    logic        key_load;
    logic [15:0] key;
    logic        keys_ready;
    logic        Encrypt;
    logic [1:0]  round_idx;
    logic [15:0] state_in;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] added_round;
    logic        out_valid;
    logic        out_err;
    logic        out_ready;

    modport master (
        output key_load, key, Encrypt, round_idx, state_in, in_valid, out_ready,
        input  keys_ready, in_ready, added_round, out_valid, out_err
    );

    modport slave (
        input  key_load, key, Encrypt, round_idx, state_in, in_valid, out_ready,
        output keys_ready, in_ready, added_round, out_valid, out_err
    );
endinterface

// File: rtl/round_key_adder.sv
// round_key_adder: S-AES key expansion plus registered state XOR round-key stage feeding SubNib
module round_key_adder #(
    parameter logic [7:0] RCON1 = 8'h80,
    parameter logic [7:0] RCON2 = 8'h30
) (
    input  logic              clk,
    input  logic              rst_n,
    round_key_adder_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, EXP1, EXP2, READY} state_t;

    state_t      state_q, state_d;
    logic [7:0]  w0_q, w1_q, w2_q, w3_q, w4_q, w5_q;
    logic [7:0]  w0_d, w1_d, w2_d, w3_d, w4_d, w5_d;
    logic        keys_ready_q, keys_ready_d;
    logic [15:0] added_q, added_d;
    logic        out_valid_q, out_valid_d;
    logic        out_err_q, out_err_d;
    logic        in_ready;
    logic        accept;
    logic [1:0]  kidx;
    logic [15:0] key_sel;

    function automatic logic [3:0] sbox(input logic [3:0] n);
        case (n)
            4'h0: return 4'h9;
            4'h1: return 4'h4;
            4'h2: return 4'hA;
            4'h3: return 4'hB;
            4'h4: return 4'hD;
            4'h5: return 4'h1;
            4'h6: return 4'h8;
            4'h7: return 4'h5;
            4'h8: return 4'h6;
            4'h9: return 4'h2;
            4'hA: return 4'h0;
            4'hB: return 4'h3;
            4'hC: return 4'hC;
            4'hD: return 4'hE;
            4'hE: return 4'hF;
            default: return 4'h7;
        endcase
    endfunction

    // SubNib(RotNib(b)): swap the nibbles, then substitute each one
    function automatic logic [7:0] sub_rot(input logic [7:0] b);
        return {sbox(b[3:0]), sbox(b[7:4])};
    endfunction

    // Key schedule: key_load restarts from any state, then two expansion steps reach READY
    always_comb begin
        state_d      = state_q;
        keys_ready_d = keys_ready_q;
        w0_d = w0_q;
        w1_d = w1_q;
        w2_d = w2_q;
        w3_d = w3_q;
        w4_d = w4_q;
        w5_d = w5_q;
        if (bus.key_load) begin
            w0_d         = bus.key[15:8];
            w1_d         = bus.key[7:0];
            keys_ready_d = 1'b0;
            state_d      = EXP1;
        end else begin
            case (state_q)
                EXP1: begin
                    w2_d    = w0_q ^ RCON1 ^ sub_rot(w1_q);
                    w3_d    = w2_d ^ w1_q;
                    state_d = EXP2;
                end
                EXP2: begin
                    w4_d         = w2_q ^ RCON2 ^ sub_rot(w3_q);
                    w5_d         = w4_d ^ w3_q;
                    keys_ready_d = 1'b1;
                    state_d      = READY;
                end
                default: state_d = state_q;
            endcase
        end
    end

    // Request path: key_load wins over accept and discards any pending result
    always_comb begin
        in_ready    = keys_ready_q & ~bus.key_load & (~out_valid_q | bus.out_ready);
        accept      = bus.in_valid & in_ready;
        kidx        = bus.Encrypt ? bus.round_idx : 2'd2 - bus.round_idx;
        key_sel     = (kidx == 2'd0) ? {w0_q, w1_q} :
                      (kidx == 2'd1) ? {w2_q, w3_q} : {w4_q, w5_q};
        added_d     = added_q;
        out_valid_d = out_valid_q;
        out_err_d   = out_err_q;
        if (bus.key_load) begin
            out_valid_d = 1'b0;
            out_err_d   = 1'b0;
        end else if (accept) begin
            out_err_d   = (bus.round_idx == 2'd3);
            added_d     = out_err_d ? bus.state_in : bus.state_in ^ key_sel;
            out_valid_d = 1'b1;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
            out_err_d   = 1'b0;
        end
    end

    // Key schedule registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            keys_ready_q <= 1'b0;
            w0_q <= 8'h00;
            w1_q <= 8'h00;
            w2_q <= 8'h00;
            w3_q <= 8'h00;
            w4_q <= 8'h00;
            w5_q <= 8'h00;
        end else begin
            state_q      <= state_d;
            keys_ready_q <= keys_ready_d;
            w0_q <= w0_d;
            w1_q <= w1_d;
            w2_q <= w2_d;
            w3_q <= w3_d;
            w4_q <= w4_d;
            w5_q <= w5_d;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            added_q     <= 16'h0000;
            out_valid_q <= 1'b0;
            out_err_q   <= 1'b0;
        end else begin
            added_q     <= added_d;
            out_valid_q <= out_valid_d;
            out_err_q   <= out_err_d;
        end
    end

    assign bus.keys_ready  = keys_ready_q;
    assign bus.in_ready    = in_ready;
    assign bus.added_round = added_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_err     = out_err_q;
endmodule
